// File: rtl/nv_nvdla_pwrbus_pkg.sv
// Shared types and parameter-legality helpers for the RAM power-down bus sequencer.
package nv_nvdla_pwrbus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        WAIT,
        DONE
    } pwrbus_seq_state_e;

    function automatic bit pwrbus_width_ok(input int unsigned pd_w, input int unsigned ngrp);
        return (ngrp != 0) && ((pd_w % ngrp) == 0);
    endfunction

    function automatic bit pwrbus_step_ok(input int unsigned step_cyc);
        return step_cyc >= 1;
    endfunction

endpackage

// File: rtl/nv_nvdla_pwrbus_step_cnt.sv
// Loadable down-counter timing the settle gap after each changed group.
module nv_nvdla_pwrbus_step_cnt #(
    parameter int unsigned STEP_CYC = 3
) (
    input  logic nvdla_core_clk,
    input  logic nvdla_core_rstn,
    input  logic load,
    output logic expire
);

    localparam int unsigned CW = $clog2(STEP_CYC + 1);

    logic [CW-1:0] cnt;

    // Loaded on the APPLY exit edge, so the value is STEP_CYC in the first WAIT cycle
    // and reaches 1 in the last one; it then parks at 0.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(STEP_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == CW'(1));

endmodule

// File: rtl/nv_nvdla_pwrbus_seq.sv
// Staggered sequencer driving pwrbus_ram_pd one group at a time with a settle gap.
module nv_nvdla_pwrbus_seq
    import nv_nvdla_pwrbus_pkg::*;
#(
    parameter int unsigned PD_W     = 32,
    parameter int unsigned NGRP     = 4,
    parameter int unsigned STEP_CYC = 3
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            pd_req_valid,
    output logic            pd_req_ready,
    input  logic [PD_W-1:0] pd_req_target,
    output logic [PD_W-1:0] pwrbus_ram_pd,
    output logic            pd_busy,
    output logic            pd_done
);

    localparam int unsigned GW    = PD_W / NGRP;
    localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

    if (!pwrbus_width_ok(PD_W, NGRP)) begin : g_bad_width
        $error("nv_nvdla_pwrbus_seq: PD_W must be a multiple of NGRP");
    end
    if (!pwrbus_step_ok(STEP_CYC)) begin : g_bad_step
        $error("nv_nvdla_pwrbus_seq: STEP_CYC must be at least 1");
    end

    pwrbus_seq_state_e state;
    logic [PD_W-1:0]   tgt_q;
    logic [GRP_W-1:0]  grp;
    logic [GW-1:0]     tgt_grp;
    logic [GW-1:0]     cur_grp;
    logic              grp_diff;
    logic              last_grp;
    logic              cnt_load;
    logic              cnt_expire;

    assign tgt_grp  = tgt_q[grp*GW +: GW];
    assign cur_grp  = pwrbus_ram_pd[grp*GW +: GW];
    assign grp_diff = (tgt_grp != cur_grp);
    assign last_grp = (grp == LAST_GRP);
    assign cnt_load = (state == APPLY) && grp_diff;

    nv_nvdla_pwrbus_step_cnt #(
        .STEP_CYC (STEP_CYC)
    ) u_step_cnt (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .load            (cnt_load),
        .expire          (cnt_expire)
    );

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state         <= IDLE;
            tgt_q         <= '0;
            grp           <= '0;
            pwrbus_ram_pd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pd_req_valid) begin
                        tgt_q <= pd_req_target;
                        grp   <= '0;
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    if (grp_diff) begin
                        pwrbus_ram_pd[grp*GW +: GW] <= tgt_grp;
                        state <= WAIT;
                    end else if (last_grp) begin
                        grp   <= '0;
                        state <= DONE;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_expire) begin
                        if (last_grp) begin
                            grp   <= '0;
                            state <= DONE;
                        end else begin
                            grp   <= grp + 1'b1;
                            state <= APPLY;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pd_req_ready = (state == IDLE);
    assign pd_busy      = (state != IDLE);
    assign pd_done      = (state == DONE);

endmodule

// File: tb/tb_nv_nvdla_pwrbus_seq.sv
// Directed bench for nv_nvdla_pwrbus_seq with a schedule-based reference model.
module tb_nv_nvdla_pwrbus_seq;

    localparam int PD_W     = 32;
    localparam int NGRP     = 4;
    localparam int STEP_CYC = 3;
    localparam int GW       = PD_W / NGRP;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            valid = 1'b0;
    logic            ready;
    logic [PD_W-1:0] target = '0;
    logic [PD_W-1:0] bus;
    logic            busy;
    logic            done;

    int n_cmp = 0;
    int n_bad = 0;
    int cur = 0;

    nv_nvdla_pwrbus_seq #(
        .PD_W     (PD_W),
        .NGRP     (NGRP),
        .STEP_CYC (STEP_CYC)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .pd_req_valid    (valid),
        .pd_req_ready    (ready),
        .pd_req_target   (target),
        .pwrbus_ram_pd   (bus),
        .pd_busy         (busy),
        .pd_done         (done)
    );

    always #5 clk = ~clk;

    // Reference model: on accept, compute when each group becomes visible and when done fires.
    logic [PD_W-1:0] m_base = '0;
    logic [PD_W-1:0] m_tgt = '0;
    int              m_k = -1;
    int              m_done = 0;
    int              m_vis[NGRP];

    function automatic logic [PD_W-1:0] m_bus_at(input int k);
        logic [PD_W-1:0] v;
        v = m_base;
        if (k >= 0) begin
            for (int g = 0; g < NGRP; g++) begin
                if (k >= m_vis[g]) v[g*GW +: GW] = m_tgt[g*GW +: GW];
            end
        end
        return v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_k    = -1;
            m_base = '0;
            m_tgt  = '0;
        end else if (m_k >= 0) begin
            m_k++;
            if (m_k > m_done) begin
                m_base = m_bus_at(m_done);
                m_k    = -1;
            end
        end else if (valid) begin
            int t;
            m_tgt = target;
            t = 1;
            for (int g = 0; g < NGRP; g++) begin
                if (m_tgt[g*GW +: GW] != m_base[g*GW +: GW]) begin
                    m_vis[g] = t + 1;
                    t += STEP_CYC + 1;
                end else begin
                    m_vis[g] = 1 << 30;
                    t += 1;
                end
            end
            m_done = t;
            m_k    = 1;
        end
    end

    task automatic check(input string name, input logic [PD_W-1:0] act, input logic [PD_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_bus",   bus,   m_bus_at(m_k));
        check("model_ready", ready, PD_W'(m_k < 0));
        check("model_busy",  busy,  PD_W'(m_k >= 0));
        check("model_done",  done,  PD_W'(m_k >= 0 && m_k == m_done));
    end

    task automatic accept(input logic [PD_W-1:0] t, input bit hold);
        @(posedge clk);
        #1;
        valid  = 1'b1;
        target = t;
        @(posedge clk);
        #1;
        if (!hold) valid = 1'b0;
        cur = 0;
    endtask

    task automatic at_cycle(input int n);
        while (cur < n) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic run_all_up();
        accept(32'hFFFF_FFFF, 1'b0);
        at_cycle(1);  check("s2_ready_c1", ready, 0);
        at_cycle(2);  check("s2_bus_c2", bus, 32'h0000_00FF);
        at_cycle(6);  check("s2_bus_c6", bus, 32'h0000_FFFF);
        at_cycle(10); check("s2_bus_c10", bus, 32'h00FF_FFFF);
        at_cycle(14); check("s2_bus_c14", bus, 32'hFFFF_FFFF);
        at_cycle(16); check("s2_done_c16", done, 0);
        at_cycle(17); check("s2_done_c17", done, 1);
                      check("s2_ready_c17", ready, 0);
        at_cycle(18); check("s2_ready_c18", ready, 1);
                      check("s2_done_c18", done, 0);
    endtask

    initial begin
        // Scenario 1: reset, then idle for 20 cycles
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("s1_bus", bus, 0);
        check("s1_ready", ready, 1);
        check("s1_busy", busy, 0);

        // Scenario 2: all groups change
        run_all_up();

        // Scenario 3: only group 1 changes
        accept(32'hFFFF_00FF, 1'b0);
        at_cycle(2); check("s3_bus_c2", bus, 32'hFFFF_FFFF);
        at_cycle(3); check("s3_bus_c3", bus, 32'hFFFF_00FF);
        at_cycle(7); check("s3_done_c7", done, 0);
        at_cycle(8); check("s3_done_c8", done, 1);
        at_cycle(9);

        // Scenario 4: target equals bus, valid held for a back-to-back accept
        accept(32'hFFFF_00FF, 1'b1);
        at_cycle(4);  check("s4_busy_c4", busy, 1);
        at_cycle(5);  check("s4_done_c5", done, 1);
                      check("s4_bus_c5", bus, 32'hFFFF_00FF);
        at_cycle(6);  check("s4_ready_c6", ready, 1);
        at_cycle(7);  check("s4_busy_c7", busy, 1);
        valid = 1'b0;
        at_cycle(11); check("s4_done_c11", done, 1);
        at_cycle(12);

        // Scenario 5: asynchronous reset mid-sequence, then a clean rerun
        @(negedge clk); #1 rstn = 1'b0;
        #1 check("s5_pre_bus", bus, 0);
        @(negedge clk); #1 rstn = 1'b1;
        accept(32'hFFFF_FFFF, 1'b0);
        at_cycle(7); check("s5_bus_c7", bus, 32'h0000_FFFF);
        #2 rstn = 1'b0;
        #1;
        check("s5_rst_bus", bus, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_ready", ready, 1);
        @(negedge clk); @(negedge clk); #1 rstn = 1'b1;
        run_all_up();

        // Scenario 6: target toggles while busy; sampled value wins
        accept(32'h0F0F_0F0F, 1'b0);
        for (int c = 1; c <= 18; c++) begin
            at_cycle(c);
            if (c == 17) check("s6_done_c17", done, 1);
            if (c == 18) check("s6_bus_c18", bus, 32'h0F0F_0F0F);
            target = $urandom;
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
